// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the back-propagation weight-update scheduler:
//   - bp_state_e : scheduler FSM states
//   - FRAC_BITS  : fraction bits of the Q8.8 fixed-point format
//   - SAT_MAX/MIN: clamp limits used when BP_SCHED_SATURATE_EN is defined
// -----------------------------------------------------------------------------
package bp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bp_state_e;

    localparam int unsigned FRAC_BITS = 32'd8;
    localparam int          SAT_MAX   = 32'sd32767;
    localparam int          SAT_MIN   = -32'sd32768;

endpackage

// File: rtl/bp_mul_pipe.sv
// -----------------------------------------------------------------------------
// bp_mul_pipe
// Two-stage Q8.8 multiply pipeline computing lr*err*fc:
//   stage 1 : p1 = (lr * err) >>> 8, fc carried alongside
//   stage 2 : p2 = (p1 * fc)  >>> 8, registered to the output
// Each stage has its own enable and valid bit so the scheduler can freeze it.
// Build option: BP_SCHED_SATURATE_EN clamps each stage result to the signed
// 16-bit range; otherwise the low DATA_W bits are kept (wrap).
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   s1_en_i, s2_en_i        per-stage advance enables
//   in_valid_i              operands on lr_i/err_i/fc_i are valid
//   lr_i, err_i, fc_i       signed Q8.8 operands
//   out_valid_o, out_data_o registered stage-2 valid and result
// -----------------------------------------------------------------------------
module bp_mul_pipe
    import bp_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s1_en_i,
    input  logic              s2_en_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] lr_i,
    input  logic [DATA_W-1:0] err_i,
    input  logic [DATA_W-1:0] fc_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o
);

    localparam int PW = 2 * DATA_W;

`ifdef BP_SCHED_SATURATE_EN
    localparam logic signed [PW-1:0] SAT_HI = PW'(SAT_MAX);
    localparam logic signed [PW-1:0] SAT_LO = PW'(SAT_MIN);
`endif

    // Arithmetic rescale of a full-width product back to Q8.8
    function automatic logic [DATA_W-1:0] rescale(input logic signed [PW-1:0] prod);
        logic signed [PW-1:0] sh;
        sh = prod >>> FRAC_BITS;
`ifdef BP_SCHED_SATURATE_EN
        if (sh > SAT_HI) begin
            return DATA_W'(SAT_MAX);
        end else if (sh < SAT_LO) begin
            return DATA_W'(SAT_MIN);
        end else begin
            return sh[DATA_W-1:0];
        end
`else
        return sh[DATA_W-1:0];
`endif
    endfunction

    logic              s1_valid_q;
    logic [DATA_W-1:0] p1_q;
    logic [DATA_W-1:0] fc1_q;
    logic              s2_valid_q;
    logic [DATA_W-1:0] p2_q;

    logic signed [PW-1:0] prod1_s;
    logic signed [PW-1:0] prod2_s;
    logic [DATA_W-1:0]    p1_d;
    logic [DATA_W-1:0]    p2_d;

    // Sign-extend operands to full product width, multiply and rescale
    always_comb begin
        prod1_s = '0;
        prod2_s = '0;
        prod1_s = $signed({{DATA_W{lr_i[DATA_W-1]}}, lr_i}) *
                  $signed({{DATA_W{err_i[DATA_W-1]}}, err_i});
        prod2_s = $signed({{DATA_W{p1_q[DATA_W-1]}}, p1_q}) *
                  $signed({{DATA_W{fc1_q[DATA_W-1]}}, fc1_q});
        p1_d    = rescale(prod1_s);
        p2_d    = rescale(prod2_s);
    end

    // Stage 1 registers: lr*err product and the fc operand it pairs with
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            p1_q       <= '0;
            fc1_q      <= '0;
        end else if (s1_en_i) begin
            s1_valid_q <= in_valid_i;
            p1_q       <= p1_d;
            fc1_q      <= fc_i;
        end
    end

    // Stage 2 registers: final product presented as the write data
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid_q <= 1'b0;
            p2_q       <= '0;
        end else if (s2_en_i) begin
            s2_valid_q <= s1_valid_q;
            p2_q       <= p2_d;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign out_data_o  = p2_q;

endmodule

// File: rtl/backprop_scheduler.sv
// -----------------------------------------------------------------------------
// backprop_scheduler
// Walks every (i,j) pair of an N_IN x N_OUT fully-connected layer, j innermost,
// fetching fc_in[i] and error[j] from external buffers (1-cycle read latency)
// and writing lr*error[j]*fc_in[i] (Q8.8) to weight address i*N_OUT+j.
// Build option: BP_SCHED_SATURATE_EN (see bp_mul_pipe) clamps stage results.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, learning_rate     pass request; lr sampled when start is accepted
//   fc_idx/fc_data           FC input buffer read index / returned data
//   err_idx/err_data         error buffer read index / returned data
//   wr_en/wr_addr/wr_data    weight write; completes when wr_ready is high
//   wr_ready                 sink ready; low while wr_en freezes the pipeline
//   busy, done               pass in progress / one-cycle end-of-pass pulse
// -----------------------------------------------------------------------------
module backprop_scheduler
    import bp_pkg::*;
#(
    parameter int N_IN   = 128,
    parameter int N_OUT  = 10,
    parameter int DATA_W = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [DATA_W-1:0]                learning_rate,
    output logic [$clog2(N_IN)-1:0]          fc_idx,
    output logic [$clog2(N_OUT)-1:0]         err_idx,
    input  logic [DATA_W-1:0]                fc_data,
    input  logic [DATA_W-1:0]                err_data,
    output logic                             wr_en,
    output logic [$clog2(N_IN*N_OUT)-1:0]    wr_addr,
    output logic [DATA_W-1:0]                wr_data,
    input  logic                             wr_ready,
    output logic                             busy,
    output logic                             done
);

    localparam int FC_IDX_W  = $clog2(N_IN);
    localparam int ERR_IDX_W = $clog2(N_OUT);
    localparam int ADDR_W    = $clog2(N_IN * N_OUT);

    bp_state_e             state_q;
    logic [FC_IDX_W-1:0]   fc_idx_q;
    logic [ERR_IDX_W-1:0]  err_idx_q;
    logic [ADDR_W-1:0]     wr_addr_q;
    logic [DATA_W-1:0]     lr_q;
    logic                  issue_v_q;   // index pair on fc_idx/err_idx is live
    logic                  fetch_v_q;   // buffer data for that pair is on the bus
    logic                  busy_q;
    logic                  done_q;

    logic                  hold_q;
    logic [DATA_W-1:0]     fc_hold_q;
    logic [DATA_W-1:0]     err_hold_q;

    logic                  stall_s;
    logic                  advance_s;
    logic                  wr_done_s;
    logic                  last_issue_s;
    logic                  last_write_s;
    logic [DATA_W-1:0]     fc_op_s;
    logic [DATA_W-1:0]     err_op_s;

    // Handshake decode, end-of-sequence detection and operand source select
    always_comb begin
        stall_s      = wr_en & ~wr_ready;
        advance_s    = ~stall_s;
        wr_done_s    = wr_en & wr_ready;
        last_issue_s = (fc_idx_q == FC_IDX_W'(N_IN - 1)) &&
                       (err_idx_q == ERR_IDX_W'(N_OUT - 1));
        last_write_s = wr_done_s && (wr_addr_q == ADDR_W'(N_IN * N_OUT - 1));
        // The buffers keep reading the frozen index during a stall, so the
        // fetch-stage operands are taken from the hold copy until released.
        fc_op_s      = hold_q ? fc_hold_q  : fc_data;
        err_op_s     = hold_q ? err_hold_q : err_data;
    end

    // Scheduler FSM with index counters, write address and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            fc_idx_q  <= '0;
            err_idx_q <= '0;
            wr_addr_q <= '0;
            lr_q      <= '0;
            issue_v_q <= 1'b0;
            fetch_v_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (advance_s) begin
                fetch_v_q <= issue_v_q;
            end
            if (wr_done_s) begin
                wr_addr_q <= wr_addr_q + ADDR_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        lr_q      <= learning_rate;
                        fc_idx_q  <= '0;
                        err_idx_q <= '0;
                        wr_addr_q <= '0;
                        issue_v_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (advance_s) begin
                        if (last_issue_s) begin
                            state_q   <= ST_DRAIN;
                            issue_v_q <= 1'b0;
                            fc_idx_q  <= '0;
                            err_idx_q <= '0;
                        end else if (err_idx_q == ERR_IDX_W'(N_OUT - 1)) begin
                            err_idx_q <= '0;
                            fc_idx_q  <= fc_idx_q + FC_IDX_W'(1);
                        end else begin
                            err_idx_q <= err_idx_q + ERR_IDX_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (last_write_s) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture the in-flight buffer data on the first stalled cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q     <= 1'b0;
            fc_hold_q  <= '0;
            err_hold_q <= '0;
        end else if (stall_s) begin
            if (!hold_q) begin
                hold_q     <= 1'b1;
                fc_hold_q  <= fc_data;
                err_hold_q <= err_data;
            end
        end else begin
            hold_q <= 1'b0;
        end
    end

    bp_mul_pipe #(
        .DATA_W (DATA_W)
    ) u_mul_pipe (
        .clk_i       (clk),
        .rst_i       (rst),
        .s1_en_i     (advance_s),
        .s2_en_i     (advance_s),
        .in_valid_i  (fetch_v_q),
        .lr_i        (lr_q),
        .err_i       (err_op_s),
        .fc_i        (fc_op_s),
        .out_valid_o (wr_en),
        .out_data_o  (wr_data)
    );

    assign fc_idx  = fc_idx_q;
    assign err_idx = err_idx_q;
    assign wr_addr = wr_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_backprop_scheduler.sv
// -----------------------------------------------------------------------------
// tb_backprop_scheduler
// Directed bench for backprop_scheduler with the default 128 x 10, Q8.8 setup.
// The FC input and error buffers are modelled as 1-cycle-latency memories.
// -----------------------------------------------------------------------------
module tb_backprop_scheduler;

    localparam int N_IN   = 128;
    localparam int N_OUT  = 10;
    localparam int DATA_W = 16;
    localparam int TOTAL  = N_IN * N_OUT;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] learning_rate;
    logic [6:0]  fc_idx;
    logic [3:0]  err_idx;
    logic [15:0] fc_data;
    logic [15:0] err_data;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic        busy;
    logic        done;

    logic [15:0] fc_mem [N_IN];
    logic [15:0] err_mem[N_OUT];

    int total = 0;
    int bad   = 0;

    // results of the most recent run_pass
    int          r_nwr, r_bad_addr, r_bad_data, r_bad_at;
    logic [15:0] r_bad_got, r_bad_exp, r_first_data;
    int          r_first_wr_cyc, r_done_cyc, r_ndone, r_busy_bad;
    int          r_stall_cyc, r_stall_bad, r_busy_after_done;
    bit          r_rst_ok;
    int          r_post_wr, r_post_done;

    backprop_scheduler #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .learning_rate(learning_rate),
        .fc_idx(fc_idx), .err_idx(err_idx), .fc_data(fc_data), .err_data(err_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // buffer memories with one cycle of read latency
    always @(posedge clk) begin
        fc_data  <= fc_mem[fc_idx];
        err_data <= err_mem[err_idx];
    end

    function automatic logic [15:0] fit(input longint v);
`ifdef BP_SCHED_SATURATE_EN
        if (v > 32767) return 16'h7FFF;
        else if (v < -32768) return 16'h8000;
        else return v[15:0];
`else
        return v[15:0];
`endif
    endfunction

    function automatic logic [15:0] model(input logic [15:0] lr, input logic [15:0] e,
                                          input logic [15:0] f);
        longint p1, p2;
        p1 = (longint'($signed(lr)) * longint'($signed(e))) >>> 8;
        p1 = longint'($signed(fit(p1)));
        p2 = (p1 * longint'($signed(f))) >>> 8;
        return fit(p2);
    endfunction

    task automatic fill(input logic [15:0] fc_v, input logic [15:0] err_v, input bit ramp);
        for (int i = 0; i < N_IN; i++) fc_mem[i] = ramp ? 16'(i << 8) : fc_v;
        for (int j = 0; j < N_OUT; j++) err_mem[j] = err_v;
    endtask

    // Drives one pass and records what the DUT did; cycle c=0 is just after
    // the edge that accepts start.
    task automatic run_pass(input logic [15:0] lr, input int stall_at, input int stall_len,
                            input int restart_at, input bit restart_on_done, input int rst_at);
        int          stall_cnt;
        logic [10:0] sa;
        logic [15:0] sd, exp_d;
        logic        prev_busy;
        r_nwr = 0; r_bad_addr = 0; r_bad_data = 0; r_bad_at = -1;
        r_bad_got = '0; r_bad_exp = '0; r_first_data = '0;
        r_first_wr_cyc = -1; r_done_cyc = -1; r_ndone = 0; r_busy_bad = 0;
        r_stall_cyc = 0; r_stall_bad = 0; r_busy_after_done = 0;
        r_rst_ok = 1'b0; r_post_wr = 0; r_post_done = 0;
        stall_cnt = 0; sa = '0; sd = '0; prev_busy = 1'b0;
        @(negedge clk);
        learning_rate = lr; start = 1'b1; wr_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                r_rst_ok = (busy === 1'b0) && (done === 1'b0) && (wr_en === 1'b0) &&
                           (fc_idx === 7'd0) && (err_idx === 4'd0) &&
                           (wr_addr === 11'd0) && (wr_data === 16'd0);
                @(negedge clk); @(negedge clk);
                rst = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(posedge clk); #1;
                    if (wr_en !== 1'b0) r_post_wr++;
                    if (done !== 1'b0) r_post_done++;
                end
                return;
            end
            start = (c == restart_at) || (restart_on_done && (done === 1'b1));
            if (wr_en === 1'b1) begin
                if (r_first_wr_cyc < 0) r_first_wr_cyc = c;
                if (r_nwr == stall_at && stall_cnt < stall_len) begin
                    wr_ready = 1'b0;
                    if (stall_cnt == 0) begin
                        sa = wr_addr; sd = wr_data;
                    end else if (wr_addr !== sa || wr_data !== sd) begin
                        r_stall_bad++;
                    end
                    stall_cnt++;
                    r_stall_cyc = stall_cnt;
                end else begin
                    wr_ready = 1'b1;
                    exp_d = (r_nwr < TOTAL) ?
                            model(lr, err_mem[r_nwr % N_OUT], fc_mem[r_nwr / N_OUT]) : 16'hxxxx;
                    if (wr_addr !== 11'(r_nwr)) begin
                        if (r_bad_addr == 0) begin r_bad_at = r_nwr; r_bad_got = 16'(wr_addr); end
                        r_bad_addr++;
                    end
                    if (wr_data !== exp_d) begin
                        if (r_bad_data == 0) begin r_bad_got = wr_data; r_bad_exp = exp_d; end
                        r_bad_data++;
                    end
                    if (r_nwr == 0) r_first_data = wr_data;
                    r_nwr++;
                end
            end else begin
                wr_ready = 1'b1;
            end
            if (done === 1'b1) begin
                r_ndone++;
                if (r_done_cyc < 0) r_done_cyc = c;
                if (busy !== 1'b0 || prev_busy !== 1'b1) r_busy_bad++;
            end
            if (r_done_cyc >= 0 && c > r_done_cyc && busy !== 1'b0) r_busy_after_done++;
            if (r_done_cyc >= 0 && c >= r_done_cyc + 3) break;
            prev_busy = busy;
            @(posedge clk); #1;
        end
        start = 1'b0; wr_ready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %0b want 0", done); end
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %0b want 0", wr_en); end
        total++; if (fc_idx !== 7'd0) begin bad++; $display("FAIL rst_fc_idx: got %0d want 0", fc_idx); end
        total++; if (err_idx !== 4'd0) begin bad++; $display("FAIL rst_err_idx: got %0d want 0", err_idx); end
        total++; if (wr_addr !== 11'd0) begin bad++; $display("FAIL rst_wr_addr: got %0d want 0", wr_addr); end
        total++; if (wr_data !== 16'd0) begin bad++; $display("FAIL rst_wr_data: got %h want 0000", wr_data); end
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %0b want 0", busy); end
    endtask

    task automatic test_basic();
        fill(16'h0000, 16'h0100, 1'b1);
        run_pass(16'h0100, -1, 0, -1, 1'b0, -1);
        total++; if (r_nwr !== TOTAL) begin bad++; $display("FAIL basic_count: got %0d want %0d", r_nwr, TOTAL); end
        total++; if (r_bad_addr !== 0) begin bad++; $display("FAIL basic_addr: write %0d got addr %0d", r_bad_at, r_bad_got); end
        total++; if (r_bad_data !== 0) begin bad++; $display("FAIL basic_data: %0d bad, got %h want %h", r_bad_data, r_bad_got, r_bad_exp); end
        total++; if (r_first_wr_cyc !== 3) begin bad++; $display("FAIL basic_first_wr: got cycle %0d want 3", r_first_wr_cyc); end
        total++; if (r_done_cyc !== 1283) begin bad++; $display("FAIL basic_done_cyc: got %0d want 1283", r_done_cyc); end
        total++; if (r_ndone !== 1) begin bad++; $display("FAIL basic_done_cnt: got %0d want 1", r_ndone); end
        total++; if (r_busy_bad !== 0) begin bad++; $display("FAIL basic_busy_fall: got %0d want 0", r_busy_bad); end
        total++; if (r_first_data !== 16'h0000) begin bad++; $display("FAIL basic_first_data: got %h want 0000", r_first_data); end
    endtask

    task automatic test_stall();
        run_pass(16'h0100, 37, 5, -1, 1'b0, -1);
        total++; if (r_stall_cyc !== 5) begin bad++; $display("FAIL stall_len: got %0d want 5", r_stall_cyc); end
        total++; if (r_stall_bad !== 0) begin bad++; $display("FAIL stall_hold: got %0d unstable cycles want 0", r_stall_bad); end
        total++; if (r_nwr !== TOTAL) begin bad++; $display("FAIL stall_count: got %0d want %0d", r_nwr, TOTAL); end
        total++; if (r_bad_addr !== 0) begin bad++; $display("FAIL stall_addr: write %0d got addr %0d", r_bad_at, r_bad_got); end
        total++; if (r_bad_data !== 0) begin bad++; $display("FAIL stall_data: %0d bad, got %h want %h", r_bad_data, r_bad_got, r_bad_exp); end
        total++; if (r_done_cyc !== 1288) begin bad++; $display("FAIL stall_done_cyc: got %0d want 1288", r_done_cyc); end
    endtask

    task automatic test_restart();
        run_pass(16'h0100, -1, 0, 100, 1'b0, -1);
        total++; if (r_nwr !== TOTAL) begin bad++; $display("FAIL restart_count: got %0d want %0d", r_nwr, TOTAL); end
        total++; if (r_done_cyc !== 1283) begin bad++; $display("FAIL restart_done_cyc: got %0d want 1283", r_done_cyc); end
        total++; if (r_ndone !== 1) begin bad++; $display("FAIL restart_done_cnt: got %0d want 1", r_ndone); end
    endtask

    task automatic test_start_in_done();
        run_pass(16'h0100, -1, 0, -1, 1'b1, -1);
        total++; if (r_ndone !== 1) begin bad++; $display("FAIL done_start_cnt: got %0d want 1", r_ndone); end
        total++; if (r_busy_after_done !== 0) begin bad++; $display("FAIL done_start_busy: got %0d busy cycles want 0", r_busy_after_done); end
    endtask

    task automatic test_reset_mid();
        run_pass(16'h0100, -1, 0, -1, 1'b0, 503);
        total++; if (r_nwr !== 500) begin bad++; $display("FAIL rstmid_before: got %0d writes want 500", r_nwr); end
        total++; if (r_rst_ok !== 1'b1) begin bad++; $display("FAIL rstmid_outputs: got %0b want 1 (all zero)", r_rst_ok); end
        total++; if (r_post_wr !== 0) begin bad++; $display("FAIL rstmid_no_write: got %0d want 0", r_post_wr); end
        total++; if (r_post_done !== 0) begin bad++; $display("FAIL rstmid_no_done: got %0d want 0", r_post_done); end
        run_pass(16'h0100, -1, 0, -1, 1'b0, -1);
        total++; if (r_nwr !== TOTAL) begin bad++; $display("FAIL rstmid_count: got %0d want %0d", r_nwr, TOTAL); end
        total++; if (r_bad_addr !== 0) begin bad++; $display("FAIL rstmid_addr: write %0d got addr %0d", r_bad_at, r_bad_got); end
        total++; if (r_done_cyc !== 1283) begin bad++; $display("FAIL rstmid_done_cyc: got %0d want 1283", r_done_cyc); end
    endtask

    task automatic test_negative();
        fill(16'h0300, 16'h0200, 1'b0);
        run_pass(16'hFF00, -1, 0, -1, 1'b0, -1);
        total++; if (r_first_data !== 16'hFA00) begin bad++; $display("FAIL neg_data: got %h want FA00", r_first_data); end
        total++; if (r_bad_data !== 0) begin bad++; $display("FAIL neg_all: %0d bad, got %h want %h", r_bad_data, r_bad_got, r_bad_exp); end
        total++; if (r_nwr !== TOTAL) begin bad++; $display("FAIL neg_count: got %0d want %0d", r_nwr, TOTAL); end
    endtask

    task automatic test_saturate();
        logic [15:0] want;
`ifdef BP_SCHED_SATURATE_EN
        want = 16'h7FFF;
`else
        want = 16'h8001;
`endif
        fill(16'h7FFF, 16'h7FFF, 1'b0);
        run_pass(16'h7FFF, -1, 0, -1, 1'b0, -1);
        total++; if (r_first_data !== want) begin bad++; $display("FAIL sat_data: got %h want %h", r_first_data, want); end
        total++; if (r_bad_data !== 0) begin bad++; $display("FAIL sat_all: %0d bad, got %h want %h", r_bad_data, r_bad_got, r_bad_exp); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; learning_rate = 16'h0000; wr_ready = 1'b1;
        fill(16'h0000, 16'h0100, 1'b1);
        test_reset();
        test_basic();
        test_stall();
        test_restart();
        test_start_in_done();
        test_reset_mid();
        test_negative();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
